// File: rtl/dram_delay_ctrl.sv
//------------------------------------------------------------------------------
// dram_delay_ctrl : programmable-length sample delay line over an external
//                   single-port distributed RAM, with RAM clear on (re)start.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dram_delay_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cfg_len,
   input  logic                  cfg_load,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_di,
   input  logic [DATA_WIDTH-1:0] ram_do
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   clr_q;
   logic [ADDR_WIDTH:0]     wp_q,   wp_d;
   logic [ADDR_WIDTH:0]     fill_q, fill_d;
   logic [ADDR_WIDTH:0]     len_q,  len_d;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic                    accept;
   logic                    full;
   logic [ADDR_WIDTH:0]     wp_inc;

   always_comb begin
      in_ready = (state_q == ST_RUN) && !cfg_load && !rst;
      accept   = in_valid && in_ready;
      full     = (fill_q == len_q);
      wp_inc   = wp_q + 1'b1;
      // Wrapping at L also covers L = D, since wp_inc can reach D in ADDR_WIDTH+1 bits.
      wp_d     = (wp_inc == len_q) ? '0 : wp_inc;
      fill_d   = full ? fill_q : fill_q + 1'b1;
      len_d    = (cfg_len == '0) ? DEPTH : {1'b0, cfg_len};

      busy     = (state_q == ST_CLEAR);
      if (state_q == ST_CLEAR) begin
         ram_addr = clr_q;
         ram_we   = 1'b1;
         ram_di   = '0;
      end else begin
         ram_addr = wp_q[ADDR_WIDTH-1:0];
         ram_we   = accept;
         ram_di   = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_q       <= '0;
         wp_q        <= '0;
         fill_q      <= '0;
         len_q       <= DEPTH;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (cfg_load) begin
         state_q     <= ST_CLEAR;
         clr_q       <= '0;
         wp_q        <= '0;
         fill_q      <= '0;
         len_q       <= len_d;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               out_valid_q <= 1'b0;
               if (clr_q == '1) begin
                  clr_q   <= '0;
                  state_q <= ST_RUN;
               end else begin
                  clr_q <= clr_q + 1'b1;
               end
            end
            ST_RUN: begin
               out_valid_q <= accept && full;
               if (accept) begin
                  // RAM read is asynchronous: ram_do still holds the old sample at wp.
                  out_data_q <= ram_do;
                  wp_q       <= wp_d;
                  fill_q     <= fill_d;
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

`default_nettype wire
